// File: rtl/reg_file_ws.sv
// Register file with a fixed number of wait states per access and byte-strobed writes.
// Define REG_FILE_WS_WPROT_EN to turn register DEPTH-1 into a write-protect mask for the others.
module reg_file_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] byte_strb,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_ready;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_error;
  logic                    r_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [BYTES-1:0]        r_strb;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_accept;
  logic                    w_direct;
  logic                    w_enter_resp;
  logic                    w_wr;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [BYTES-1:0]        w_strb;
  logic [ADDR_WIDTH-1:0]   w_idx_full;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_bad;
  logic                    w_prot;
  logic                    w_err;

  assign w_accept     = req & r_ready;
  // With zero wait states the access completes on its own accept edge, straight from the ports.
  assign w_direct     = w_accept && (WAIT_STATES == 0);
  assign w_enter_resp = w_direct || (r_state == WAIT && r_cnt == 4'd0);

  assign w_wr    = w_direct ? wr_en     : r_wr;
  assign w_addr  = w_direct ? address   : r_addr;
  assign w_wdata = w_direct ? wr_data   : r_wdata;
  assign w_strb  = w_direct ? byte_strb : r_strb;

  assign w_idx_full = w_addr >> OFF_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_bad      = (w_idx_full >= ADDR_WIDTH'(DEPTH)) || (|(w_addr & OFF_MASK));

`ifdef REG_FILE_WS_WPROT_EN
  assign w_prot = w_wr && (w_idx != IDX_W'(DEPTH - 1)) && r_mem[DEPTH-1][w_idx];
`else
  assign w_prot = 1'b0;
`endif

  assign w_err = w_bad || w_prot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rd_data    <= '0;
      r_error      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_strb       <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= wr_en;
        r_addr  <= address;
        r_wdata <= wr_data;
        r_strb  <= byte_strb;
        if (WAIT_STATES > 0) begin
          r_state <= WAIT;
          r_cnt   <= CNT_INIT;
          r_ready <= 1'b0;
        end else begin
          r_state <= RESP;
          r_ready <= 1'b1;
        end
      end else begin
        case (r_state)
          WAIT: begin
            if (r_cnt == 4'd0) begin
              r_state <= RESP;
              r_ready <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          RESP:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end

      r_resp_valid <= w_enter_resp;
      // Completion: commit the write or capture read data, both on the edge entering RESP.
      if (w_enter_resp) begin
        r_error   <= w_err;
        r_rd_data <= (!w_wr && !w_err) ? r_mem[w_idx] : '0;
        if (w_wr && !w_err) begin
          for (int b = 0; b < BYTES; b++) begin
            if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign rd_data    = r_rd_data;
  assign error      = r_error;

endmodule

// File: tb/tb_reg_file_ws.sv
// Scoreboard bench for reg_file_ws: one instance with one wait state, one with none.
module tb_reg_file_ws;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    longint      cyc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance with WAIT_STATES=1
  logic        req1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [3:0]  strb1 = '0;
  logic        ready1, rv1, err1;
  logic [31:0] rd1;

  reg_file_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr_en(wr1), .address(addr1), .wr_data(wdata1),
    .byte_strb(strb1), .req_ready(ready1), .resp_valid(rv1), .rd_data(rd1), .error(err1));

  // Instance with WAIT_STATES=0
  logic        req0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  strb0 = '0;
  logic        ready0, rv0, err0;
  logic [31:0] rd0;

  reg_file_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr_en(wr0), .address(addr0), .wr_data(wdata0),
    .byte_strb(strb0), .req_ready(ready0), .resp_valid(rv0), .rd_data(rd0), .error(err0));

  exp_t q1[$];
  exp_t q0[$];
  int   run0 = 0, max_run0 = 0;
  int   id_ctr = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (resp %0d): got %h expected %h", nm, id, got, exp);
    end
  endtask

  // Monitors: pop and compare on every response pulse
  always @(negedge clk) begin
    if (rst && rv1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp1: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("rd_data1", e.id, 64'(rd1), 64'(e.rd));
        chk("error1", e.id, 64'(err1), 64'(e.err));
        chk("latency1", e.id, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rv0) begin
      run0 = run0 + 1;
      if (run0 > max_run0) max_run0 = run0;
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp0: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("rd_data0", e.id, 64'(rd0), 64'(e.rd));
        chk("error0", e.id, 64'(err0), 64'(e.err));
        chk("latency0", e.id, 64'(cyc), 64'(e.cyc));
      end
    end else begin
      run0 = 0;
    end
  end

  // Issue one access to the one-wait-state instance; expectation pushed when accepted.
  task automatic acc1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err,
                      input bit push);
    int guard;
    exp_t e;
    @(negedge clk);
    req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; strb1 = s;
    guard = 0;
    while (!ready1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready1) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout1: got req_ready=0 expected 1 within 50 cycles");
    end
    if (push) begin
      e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + 2; e.id = id_ctr;
      q1.push_back(e);
    end
    id_ctr++;
    @(posedge clk);
  endtask

  task automatic idle1();
    @(negedge clk);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", -1, 64'(ready1), 64'd1);
    chk("reset_valid", -1, 64'(rv1), 64'd0);
    chk("reset_rd", -1, 64'(rd1), 64'd0);
    chk("reset_err", -1, 64'(err1), 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Basic write then read; data changes during WAIT must not leak in
    acc1(1'b1, 32'h4, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, 32'hA5A5_0001, 1'b0, 1'b1);
    // Byte strobes
    acc1(1'b1, 32'h8, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1);
    acc1(1'b1, 32'h8, 32'hFFFF_FFFF, 4'h5, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h8, 32'h0, 4'h0, 32'h11FF_33FF, 1'b0, 1'b1);
    acc1(1'b1, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h8, 32'h0, 4'hF, 32'h11FF_33FF, 1'b0, 1'b1);
    // Out-of-range and misaligned
    acc1(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    acc1(1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    acc1(1'b1, 32'h40, 32'h7777_7777, 4'hF, 32'h0, 1'b1, 1'b1);
    acc1(1'b1, 32'h5, 32'h6666_6666, 4'hF, 32'h0, 1'b1, 1'b1);
    acc1(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h4, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0, 1'b1);
    // Register 15: protect mask when enabled, plain storage otherwise
    acc1(1'b1, 32'h3C, 32'h2, 4'hF, 32'h0, 1'b0, 1'b1);
`ifdef REG_FILE_WS_WPROT_EN
    acc1(1'b1, 32'h4, 32'h55, 4'hF, 32'h0, 1'b1, 1'b1);
    acc1(1'b0, 32'h4, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0, 1'b1);
`else
    acc1(1'b1, 32'h4, 32'h55, 4'hF, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h4, 32'h0, 4'h0, 32'h55, 1'b0, 1'b1);
`endif
    acc1(1'b0, 32'h3C, 32'h0, 4'h0, 32'h2, 1'b0, 1'b1);
    acc1(1'b1, 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    acc1(1'b1, 32'h4, 32'h55, 4'hF, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h4, 32'h0, 4'h0, 32'h55, 1'b0, 1'b1);
    idle1();

    // Reset during WAIT aborts the write; no response expected
    acc1(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_ready", -1, 64'(ready1), 64'd1);
    chk("abort_valid", -1, 64'(rv1), 64'd0);
    chk("abort_rd", -1, 64'(rd1), 64'd0);
    @(posedge clk); #2 rst = 1'b1;
    acc1(1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    acc1(1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    idle1();

    // Zero wait states: 4 writes then 4 reads back-to-back with req held
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      @(negedge clk);
      if (k > 0) chk("b2b_ready0", k, 64'(ready0), 64'd1);
      req0 = 1'b1; wr0 = (k < 4); addr0 = 32'((k % 4) * 4);
      wdata0 = 32'h1000_0000 + 32'(k); strb0 = 4'hF;
      e.rd = (k < 4) ? 32'h0 : 32'h1000_0000 + 32'(k - 4);
      e.err = 1'b0; e.cyc = cyc + 1; e.id = 100 + k;
      q0.push_back(e);
    end
    @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_run0", -1, 64'(max_run0), 64'd8);

    chk("drain_q1", -1, 64'(q1.size()), 64'd0);
    chk("drain_q0", -1, 64'(q0.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_ws.md
REG_FILE_WS -- requirements
Module: reg_file_ws

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 16: number of registers; SHALL be 2..DATA_WIDTH.
REQ-004 Parameter WAIT_STATES, default 1: wait cycles per access; SHALL be 0..15.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req  input  1  access request, sampled when req_ready=1.
REQ-008 wr_en  input  1  1=write, 0=read; qualified by req.
REQ-009 address  input  ADDR_WIDTH  byte address of access.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 byte_strb  input  DATA_WIDTH/8  per-byte write enable; ignored on reads.
REQ-012 req_ready  output  1  block can accept a request this cycle.
REQ-013 resp_valid  output  1  one-cycle pulse; completes an access.
REQ-014 rd_data  output  DATA_WIDTH  read result; valid when resp_valid=1.
REQ-015 error  output  1  access failed; valid when resp_valid=1.

Function
REQ-016 Index SHALL be address >> log2(DATA_WIDTH/8); access SHALL be erroneous if index >= DEPTH or address low log2(DATA_WIDTH/8) bits are nonzero.
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 in IDLE and RESP, 0 in WAIT.
REQ-018 Accept = req & req_ready; on accept the block SHALL latch wr_en, address, wr_data, byte_strb; later input changes SHALL have no effect on the accepted access.
REQ-019 On accept: to WAIT with wait counter loaded WAIT_STATES-1 if WAIT_STATES>0, else directly to RESP.
REQ-020 WAIT: counter decrements each cycle; at 0 go to RESP; no new request accepted.
REQ-021 Response latency SHALL be exactly WAIT_STATES+1 cycles from accept edge to resp_valid=1.
REQ-022 RESP: resp_valid=1 for exactly one cycle; if accept occurs in RESP, next state per REQ-019 (back-to-back, no idle bubble); else IDLE.
REQ-023 Write SHALL commit on the edge entering RESP, updating only bytes with byte_strb bit set; errored writes SHALL not modify storage.
REQ-024 Read data SHALL be registered on the edge entering RESP and held until the next response; errored reads SHALL return all-zero rd_data.
REQ-025 Write with byte_strb=0 SHALL complete normally, error=0, storage unchanged.
REQ-026 rd_data after a write response SHALL be all-zero.
REQ-027 error SHALL be held until the next response, zero after reset.

Reset
REQ-028 While rst=0: state IDLE, all registers 0, req_ready=1, resp_valid=0, rd_data=0, error=0, wait counter 0.
REQ-029 Reset asserted mid-access SHALL abort it: no response, pending write discarded.
REQ-030 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro REG_FILE_WS_WPROT_EN SHALL enable write protection.
REQ-032 With macro: register DEPTH-1 is a protect mask; bit i=1 makes register i (i<DEPTH-1) read-only; write to a protected register completes with error=1, storage unchanged; register DEPTH-1 always writable.
REQ-033 Without macro: register DEPTH-1 is ordinary storage; no write ever errors except per REQ-016.

Verification
REQ-034 WAIT_STATES=1; write 0xA5A5_0001 to addr 0x4, strb 0xF; then read 0x4 -> each resp_valid 2 cycles after accept, rd_data=0xA5A5_0001, error=0.
REQ-035 Reg 2 = 0x1122_3344; write 0xFFFF_FFFF to 0x8, strb 0x5 -> read 0x8 returns 0x11FF_33FF.
REQ-036 DEPTH=16: read 0x40 and read 0x6 -> both error=1, rd_data=0; write 0x40 changes no register.
REQ-037 WAIT_STATES=0; req held high for 4 reads 0x0..0xC -> resp_valid high 4 consecutive cycles, req_ready constant 1.
REQ-038 Write 0xDEAD_BEEF to 0x4, rst low during WAIT -> no resp_valid; after reset read 0x4 returns 0.
REQ-039 WPROT_EN, DEPTH=16: write 0x2 to 0x3C, then write 0x55 to 0x4 -> error=1, reg 1 unchanged; write 0x0 to 0x3C, repeat -> error=0, reg 1=0x55.
